// File: rtl/postadder_nthread.sv
// rtl/postadder_nthread.sv - thread-interleaved recombination of three partial products into (Z0, Z1).
// Optional mode-11 negation is built only when POSTADDER_NEG_EN is defined.
module postadder_nthread #(
  parameter int W         = 64,
  parameter int N_THREADS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [W-1:0]                 in_data,
  input  logic [1:0]                   mode,
  output logic                         out_valid,
  output logic [$clog2(N_THREADS)-1:0] out_thread,
  output logic [W-1:0]                 Z0,
  output logic [W-1:0]                 Z1,
  output logic                         sync_err
);
  localparam int TW = $clog2(N_THREADS);

  logic [TW-1:0] t, t_eff;
  logic [1:0]    ph, ph_eff;
  logic          resync;

  logic [W-1:0] p0_mem   [N_THREADS];
  logic [W-1:0] p1_mem   [N_THREADS];
  logic [W-1:0] s_mem    [N_THREADS];
  logic [W-1:0] d_mem    [N_THREADS];
  logic [1:0]   mode_mem [N_THREADS];

  logic [W-1:0] z0_n, z1_n;

  // A start-of-group beat is always processed as thread 0 / phase 0.
  always_comb begin
    resync = in_valid && in_sof;
    t_eff  = resync ? '0 : t;
    ph_eff = resync ? 2'd0 : ph;
  end

  always_comb begin
    z0_n = '0;
    z1_n = '0;
    case (mode_mem[t_eff])
      2'b00: begin
        z0_n = p0_mem[t_eff];
        z1_n = p1_mem[t_eff];
      end
      2'b01: begin
        z0_n = d_mem[t_eff];
        z1_n = in_data - s_mem[t_eff];
      end
      2'b10: begin
        z0_n = s_mem[t_eff];
        z1_n = in_data;
      end
      default: begin
`ifdef POSTADDER_NEG_EN
        z0_n = '0 - p0_mem[t_eff];
        z1_n = '0 - p1_mem[t_eff];
`else
        z0_n = '0;
        z1_n = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t          <= '0;
      ph         <= 2'd0;
      out_valid  <= 1'b0;
      out_thread <= '0;
      Z0         <= '0;
      Z1         <= '0;
      sync_err   <= 1'b0;
      for (int i = 0; i < N_THREADS; i++) begin
        p0_mem[i]   <= '0;
        p1_mem[i]   <= '0;
        s_mem[i]    <= '0;
        d_mem[i]    <= '0;
        mode_mem[i] <= 2'b00;
      end
    end else begin
      out_valid <= in_valid && (ph_eff == 2'd2);
      if (in_valid) begin
        if (resync && (t != '0 || ph != 2'd0))
          sync_err <= 1'b1;
        case (ph_eff)
          2'd0: begin
            p0_mem[t_eff]   <= in_data;
            mode_mem[t_eff] <= mode;
          end
          2'd1: begin
            p1_mem[t_eff] <= in_data;
            s_mem[t_eff]  <= p0_mem[t_eff] + in_data;
            d_mem[t_eff]  <= p0_mem[t_eff] - in_data;
          end
          default: begin
            Z0         <= z0_n;
            Z1         <= z1_n;
            out_thread <= t_eff;
          end
        endcase
        if (t_eff == TW'(N_THREADS - 1)) begin
          t  <= '0;
          ph <= (ph_eff == 2'd2) ? 2'd0 : ph_eff + 2'd1;
        end else begin
          t  <= t_eff + 1'b1;
          ph <= ph_eff;
        end
      end
    end
  end
endmodule

// File: tb/tb_postadder_nthread.sv
// tb/tb_postadder_nthread.sv - directed self-checking bench for postadder_nthread (W=64, N_THREADS=4).
module tb_postadder_nthread;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [63:0] in_data = '0;
  logic [1:0]  mode = 2'b00;
  logic        out_valid;
  logic [1:0]  out_thread;
  logic [63:0] Z0, Z1;
  logic        sync_err;

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] exp_z0 [4];
  logic [63:0] exp_z1 [4];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  postadder_nthread #(.W(64), .N_THREADS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .mode(mode), .out_valid(out_valid), .out_thread(out_thread), .Z0(Z0), .Z1(Z1),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic sof, input logic [63:0] d, input logic [1:0] m,
                      input logic exp_ov, input logic [1:0] th);
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    mode     = m;
    @(posedge clk);
    #1;
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      check("out_thread", out_thread, th);
      check("Z0", Z0, exp_z0[th]);
      check("Z1", Z1, exp_z1[th]);
    end
  endtask

  // Full group; bubbles may carry in_sof=1 with in_valid=0, which must be ignored.
  task automatic run_group(input logic [7:0] modes, input logic [63:0] p0, input logic [63:0] p1,
                           input logic [63:0] p2, input logic first_sof, input int bubble_pct);
    logic [63:0] d;
    for (int ph = 0; ph < 3; ph++) begin
      for (int th = 0; th < 4; th++) begin
        while ($urandom_range(99) < bubble_pct)
          step(1'b0, 1'b1, 64'hDEAD_BEEF, 2'b11, 1'b0, 2'd0);
        d = (ph == 0) ? p0 : (ph == 1) ? p1 : p2;
        step(1'b1, first_sof && ph == 0 && th == 0, d, modes[2*th +: 2], ph == 2, 2'(th));
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // First n beats of a group with deliberately different data; no output may appear.
  task automatic partial(input int n);
    for (int b = 0; b < n; b++)
      step(1'b1, 1'b0, 64'd100 + 64'(b), 2'b10, 1'b0, 2'd0);
  endtask

  task automatic set_exp(input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] b0,
                         input logic [63:0] b1, input logic [63:0] c0, input logic [63:0] c1,
                         input logic [63:0] e0, input logic [63:0] e1);
    exp_z0[0] = a0; exp_z1[0] = a1;
    exp_z0[1] = b0; exp_z1[1] = b1;
    exp_z0[2] = c0; exp_z1[2] = c1;
    exp_z0[3] = e0; exp_z1[3] = e1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_Z0", Z0, 0);
    check("rst_Z1", Z1, 0);
    check("rst_thread", out_thread, 0);
    check("rst_sync_err", sync_err, 0);
    rst = 1'b0;

    // Karatsuba: 10-3=7, 40-(10+3)=27; continuous valid, no in_sof.
    set_exp(7, 27, 7, 27, 7, 27, 7, 27);
    run_group(8'b01_01_01_01, 10, 3, 40, 1'b0, 0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);
    check("hold_Z0", Z0, 7);
    check("sync_err_t1", sync_err, 0);

    // Wrap: D = 0-1, P2-S = 0-1; aligned in_sof raises no error.
    set_exp(ONES, ONES, ONES, ONES, ONES, ONES, ONES, ONES);
    run_group(8'b01_01_01_01, 0, 1, 0, 1'b1, 0);
    check("sync_err_aligned", sync_err, 0);

    // Mixed modes t0=00 t1=10 t2=01 t3=10 with bubbles.
    set_exp(5, 2, 7, 9, 3, 2, 7, 9);
    run_group(8'b10_01_10_00, 5, 2, 9, 1'b0, 30);
    check("sync_err_idle_sof", sync_err, 0);

    // Resync on beat 7 of a group.
    partial(6);
    check("sync_err_pre", sync_err, 0);
    set_exp(7, 27, 7, 27, 7, 27, 7, 27);
    run_group(8'b01_01_01_01, 10, 3, 40, 1'b1, 0);
    check("sync_err_set", sync_err, 1);
    run_group(8'b01_01_01_01, 10, 3, 40, 1'b0, 0);
    check("sync_err_sticky", sync_err, 1);

    // Reset mid-phase 1, then a group without in_sof.
    partial(6);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_Z0", Z0, 0);
    check("mid_rst_Z1", Z1, 0);
    check("mid_rst_thread", out_thread, 0);
    check("mid_rst_sync_err", sync_err, 0);
    set_exp(7, 9, 7, 9, 7, 9, 7, 9);
    run_group(8'b10_10_10_10, 5, 2, 9, 1'b0, 0);
    check("sync_err_post_rst", sync_err, 0);

    // Mode 11 on threads 1 and 3, sum mode on threads 0 and 2: P0=1, P1=2, P2=4.
`ifdef POSTADDER_NEG_EN
    set_exp(3, 4, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 3, 4, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
`else
    set_exp(3, 4, 0, 0, 3, 4, 0, 0);
`endif
    run_group(8'b11_10_11_10, 1, 2, 4, 1'b0, 20);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
